mem_ctrl: RTL and testbench

- Memory-side responder for the ROB store-commit interface (rob2mem_*, mem_busy) and the load/fetch result interface (mem_valid, mem_dependency, mem_value).
- Arbitrates instruction fetch (IF), loads (LSB) and committed stores (ROB) onto the byte-serial RAM port: 8-bit data, 1-cycle read latency, little-endian.
- Returns load results tagged with a ROB id, and fetched instructions to IF.

---
 rtl/mem_ctrl_pkg.sv | 37 +++
 rtl/mem_ctrl.sv | 229 ++++++++++++++++++++++
 tb/tb_mem_ctrl.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_ctrl_pkg.sv
// Shared encodings for the memory controller: access types, FSM states, store latch.
// Access length is derived from the low two bits of the load/store type.
package mem_ctrl_pkg;

    localparam int DEF_ROB_SIZE_WIDTH = 5;

    localparam logic [2:0] STORE_BYTE = 3'd0;
    localparam logic [2:0] STORE_HALF = 3'd1;
    localparam logic [2:0] STORE_WORD = 3'd2;

    localparam logic [2:0] LOAD_LB  = 3'd0;
    localparam logic [2:0] LOAD_LH  = 3'd1;
    localparam logic [2:0] LOAD_LW  = 3'd2;
    localparam logic [2:0] LOAD_LBU = 3'd4;
    localparam logic [2:0] LOAD_LHU = 3'd5;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_LOAD  = 2'd2;
    localparam logic [1:0] ST_STORE = 2'd3;

    typedef struct packed {
        logic [2:0]  acc_type;
        logic [31:0] addr;
        logic [31:0] value;
    } store_req_t;

    // Index of the final byte of an access: 0 for byte, 1 for half, 3 for word.
    function automatic logic [1:0] last_byte_idx(input logic [2:0] acc_type);
        case (acc_type[1:0])
            2'd0:    return 2'd0;
            2'd1:    return 2'd1;
            default: return 2'd3;
        endcase
    endfunction

endpackage

// File: rtl/mem_ctrl.sv
// Byte-serial RAM arbiter: pending store > load > fetch; read data arrives one edge after its address.
// Results are single-cycle pulses; rdy_in low freezes the sequence and masks mem_wr.
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int ROB_SIZE_WIDTH = DEF_ROB_SIZE_WIDTH,
    parameter int ADDR_WIDTH     = 32
) (
    input  logic                      clk_in,
    input  logic                      rst_in,
    input  logic                      rdy_in,

    input  logic [7:0]                mem_din,
    output logic [7:0]                mem_dout,
    output logic [ADDR_WIDTH-1:0]     mem_a,
    output logic                      mem_wr,

    input  logic                      rob2mem_ready,
    input  logic [2:0]                rob2mem_store_type,
    input  logic [31:0]               rob2mem_addr,
    input  logic [31:0]               rob2mem_value,
    output logic                      mem_busy,

    input  logic                      lsb2mem_ready,
    input  logic [2:0]                lsb2mem_load_type,
    input  logic [31:0]               lsb2mem_addr,
    input  logic [ROB_SIZE_WIDTH-1:0] lsb2mem_rob_id,

    input  logic                      if2mem_ready,
    input  logic [31:0]               if2mem_addr,

    input  logic                      need_flush_in,

    output logic                      mem_valid,
    output logic [ROB_SIZE_WIDTH-1:0] mem_dependency,
    output logic [31:0]               mem_value,
    output logic                      mem2if_valid,
    output logic [31:0]               mem2if_instr
);

    logic [1:0]                state_q,    state_d;
    logic [1:0]                cnt_q,      cnt_d;
    logic [1:0]                last_q,     last_d;
    logic [2:0]                ld_type_q,  ld_type_d;
    logic [ROB_SIZE_WIDTH-1:0] rob_id_q,   rob_id_d;
    logic [31:0]               data_q,     data_d;
    logic [23:0]               st_shift_q, st_shift_d;
    logic                      pend_q,     pend_d;
    store_req_t                pend_req_q, pend_req_d;
    logic [ADDR_WIDTH-1:0]     mem_a_q,    mem_a_d;
    logic [7:0]                mem_dout_q, mem_dout_d;
    logic                      mem_wr_q,   mem_wr_d;
    logic                      valid_q,    valid_d;
    logic                      if_valid_q, if_valid_d;
    logic [31:0]               value_q,    value_d;
    logic [31:0]               instr_q,    instr_d;
    logic [ROB_SIZE_WIDTH-1:0] dep_q,      dep_d;
    logic [31:0]               rd_word;

    function automatic logic [31:0] extend_load(input logic [2:0] ld_type, input logic [31:0] w);
        case (ld_type)
            LOAD_LB:  return {{24{w[7]}}, w[7:0]};
            LOAD_LH:  return {{16{w[15]}}, w[15:0]};
            LOAD_LBU: return {24'h000000, w[7:0]};
            LOAD_LHU: return {16'h0000, w[15:0]};
            default:  return w;
        endcase
    endfunction

    function automatic logic [31:0] merge_byte(input logic [31:0] w, input logic [1:0] idx,
                                               input logic [7:0] b);
        logic [31:0] r;
        r = w;
        case (idx)
            2'd0:    r[7:0]   = b;
            2'd1:    r[15:8]  = b;
            2'd2:    r[23:16] = b;
            default: r[31:24] = b;
        endcase
        return r;
    endfunction

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        last_d     = last_q;
        ld_type_d  = ld_type_q;
        rob_id_d   = rob_id_q;
        data_d     = data_q;
        st_shift_d = st_shift_q;
        pend_d     = pend_q;
        pend_req_d = pend_req_q;
        mem_a_d    = mem_a_q;
        mem_dout_d = mem_dout_q;
        mem_wr_d   = mem_wr_q;
        valid_d    = 1'b0;
        if_valid_d = 1'b0;
        value_d    = value_q;
        instr_d    = instr_q;
        dep_d      = dep_q;
        rd_word    = merge_byte(data_q, cnt_q, mem_din);

        // Committed stores are latched regardless of state or pause; a second pulse is dropped.
        if (rob2mem_ready && !pend_q) begin
            pend_d     = 1'b1;
            pend_req_d = '{acc_type: rob2mem_store_type, addr: rob2mem_addr, value: rob2mem_value};
        end

        if (rdy_in) begin
            case (state_q)
                ST_IDLE: begin
                    mem_wr_d = 1'b0;
                    if (pend_q) begin
                        state_d    = ST_STORE;
                        pend_d     = 1'b0;
                        cnt_d      = 2'd0;
                        last_d     = last_byte_idx(pend_req_q.acc_type);
                        mem_a_d    = pend_req_q.addr[ADDR_WIDTH-1:0];
                        mem_wr_d   = 1'b1;
                        mem_dout_d = pend_req_q.value[7:0];
                        st_shift_d = pend_req_q.value[31:8];
                    end else if (!need_flush_in && lsb2mem_ready) begin
                        state_d   = ST_LOAD;
                        cnt_d     = 2'd0;
                        last_d    = last_byte_idx(lsb2mem_load_type);
                        ld_type_d = lsb2mem_load_type;
                        rob_id_d  = lsb2mem_rob_id;
                        mem_a_d   = lsb2mem_addr[ADDR_WIDTH-1:0];
                        data_d    = 32'h0;
                    end else if (!need_flush_in && if2mem_ready) begin
                        state_d = ST_FETCH;
                        cnt_d   = 2'd0;
                        last_d  = 2'd3;
                        mem_a_d = if2mem_addr[ADDR_WIDTH-1:0];
                        data_d  = 32'h0;
                    end
                end
                ST_FETCH, ST_LOAD: begin
                    if (need_flush_in) begin
                        state_d = ST_IDLE;
                    end else begin
                        data_d = rd_word;
                        if (cnt_q == last_q) begin
                            state_d = ST_IDLE;
                            if (state_q == ST_LOAD) begin
                                valid_d = 1'b1;
                                value_d = extend_load(ld_type_q, rd_word);
                                dep_d   = rob_id_q;
                            end else begin
                                if_valid_d = 1'b1;
                                instr_d    = rd_word;
                            end
                        end else begin
                            cnt_d   = cnt_q + 2'd1;
                            mem_a_d = mem_a_q + ADDR_WIDTH'(1);
                        end
                    end
                end
                ST_STORE: begin
                    if (cnt_q == last_q) begin
                        state_d  = ST_IDLE;
                        mem_wr_d = 1'b0;
                    end else begin
                        cnt_d      = cnt_q + 2'd1;
                        mem_a_d    = mem_a_q + ADDR_WIDTH'(1);
                        mem_dout_d = st_shift_q[7:0];
                        st_shift_d = {8'h00, st_shift_q[23:8]};
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end else if ((state_q == ST_FETCH || state_q == ST_LOAD) && need_flush_in) begin
            // A flush is never lost to a pause: speculative reads are dropped immediately.
            state_d = ST_IDLE;
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 2'd0;
            last_q     <= 2'd0;
            ld_type_q  <= 3'd0;
            rob_id_q   <= '0;
            data_q     <= 32'h0;
            st_shift_q <= 24'h0;
            pend_q     <= 1'b0;
            pend_req_q <= '0;
            mem_a_q    <= '0;
            mem_dout_q <= 8'h00;
            mem_wr_q   <= 1'b0;
            valid_q    <= 1'b0;
            if_valid_q <= 1'b0;
            value_q    <= 32'h0;
            instr_q    <= 32'h0;
            dep_q      <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            last_q     <= last_d;
            ld_type_q  <= ld_type_d;
            rob_id_q   <= rob_id_d;
            data_q     <= data_d;
            st_shift_q <= st_shift_d;
            pend_q     <= pend_d;
            pend_req_q <= pend_req_d;
            mem_a_q    <= mem_a_d;
            mem_dout_q <= mem_dout_d;
            mem_wr_q   <= mem_wr_d;
            valid_q    <= valid_d;
            if_valid_q <= if_valid_d;
            value_q    <= value_d;
            instr_q    <= instr_d;
            dep_q      <= dep_d;
        end
    end

    // Masking the write strobe during a pause means the held byte is written once rdy_in returns.
    assign mem_wr         = mem_wr_q & rdy_in;
    assign mem_a          = mem_a_q;
    assign mem_dout       = mem_dout_q;
    assign mem_busy       = (state_q != ST_IDLE) | pend_q;
    assign mem_valid      = valid_q;
    assign mem_dependency = dep_q;
    assign mem_value      = value_q;
    assign mem2if_valid   = if_valid_q;
    assign mem2if_instr   = instr_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Scoreboard bench for mem_ctrl: stimulus queues expected results with their cycle stamps,
// a negedge monitor pops them whenever the controller writes or pulses a result.
module tb_mem_ctrl;
    import mem_ctrl_pkg::*;

    logic        clk_in = 1'b0;
    logic        rst_in, rdy_in;
    logic [7:0]  mem_din, mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic        rob2mem_ready;
    logic [2:0]  rob2mem_store_type;
    logic [31:0] rob2mem_addr, rob2mem_value;
    logic        mem_busy;
    logic        lsb2mem_ready;
    logic [2:0]  lsb2mem_load_type;
    logic [31:0] lsb2mem_addr;
    logic [4:0]  lsb2mem_rob_id;
    logic        if2mem_ready;
    logic [31:0] if2mem_addr;
    logic        need_flush_in;
    logic        mem_valid;
    logic [4:0]  mem_dependency;
    logic [31:0] mem_value;
    logic        mem2if_valid;
    logic [31:0] mem2if_instr;

    mem_ctrl #(.ROB_SIZE_WIDTH(5), .ADDR_WIDTH(32)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
        .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
        .rob2mem_ready(rob2mem_ready), .rob2mem_store_type(rob2mem_store_type),
        .rob2mem_addr(rob2mem_addr), .rob2mem_value(rob2mem_value), .mem_busy(mem_busy),
        .lsb2mem_ready(lsb2mem_ready), .lsb2mem_load_type(lsb2mem_load_type),
        .lsb2mem_addr(lsb2mem_addr), .lsb2mem_rob_id(lsb2mem_rob_id),
        .if2mem_ready(if2mem_ready), .if2mem_addr(if2mem_addr),
        .need_flush_in(need_flush_in),
        .mem_valid(mem_valid), .mem_dependency(mem_dependency), .mem_value(mem_value),
        .mem2if_valid(mem2if_valid), .mem2if_instr(mem2if_instr)
    );

    always #5 clk_in = ~clk_in;

    // RAM model: the address registered at one edge is read back at the next edge.
    logic [7:0]  ram [0:65535];
    logic        pl_en = 1'b0;
    logic [15:0] pl_a = 16'h0;
    logic [7:0]  pl_d = 8'h0;
    assign mem_din = ram[mem_a[15:0]];
    always @(posedge clk_in) begin
        if (mem_wr)     ram[mem_a[15:0]] <= mem_dout;
        else if (pl_en) ram[pl_a] <= pl_d;
    end

    typedef struct { int cyc; logic [4:0] dep; logic [31:0] val; } ld_exp_t;
    typedef struct { int cyc; logic [31:0] instr; }                 if_exp_t;
    typedef struct { int cyc; logic [31:0] addr; logic [7:0] dat; } wr_exp_t;
    ld_exp_t ld_q[$];
    if_exp_t if_q[$];
    wr_exp_t wr_q[$];

    int n_checks = 0;
    int n_fails  = 0;
    int cyc      = 0;
    always @(posedge clk_in) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic unexpected(input string name);
        n_checks++;
        n_fails++;
        $display("FAIL %s: output pulse with empty scoreboard (cycle %0d)", name, cyc);
    endtask

    always @(negedge clk_in) begin : monitor
        ld_exp_t le;
        if_exp_t ie;
        wr_exp_t we;
        if (mem_valid) begin
            if (ld_q.size() == 0) unexpected("load_valid");
            else begin
                le = ld_q.pop_front();
                check("load_cycle", 64'(cyc), 64'(le.cyc));
                check("load_dep",   64'(mem_dependency), 64'(le.dep));
                check("load_value", 64'(mem_value), 64'(le.val));
            end
        end
        if (mem2if_valid) begin
            if (if_q.size() == 0) unexpected("fetch_valid");
            else begin
                ie = if_q.pop_front();
                check("fetch_cycle", 64'(cyc), 64'(ie.cyc));
                check("fetch_instr", 64'(mem2if_instr), 64'(ie.instr));
            end
        end
        if (mem_wr) begin
            if (wr_q.size() == 0) unexpected("ram_write");
            else begin
                we = wr_q.pop_front();
                check("write_cycle", 64'(cyc), 64'(we.cyc));
                check("write_addr",  64'(mem_a), 64'(we.addr));
                check("write_data",  64'(mem_dout), 64'(we.dat));
            end
        end
    end

    localparam logic [23:0] PRE [18] = '{
        24'h1000_78, 24'h1001_56, 24'h1002_34, 24'h1003_12,
        24'h1100_80, 24'h1101_FF, 24'h1200_FF, 24'h1201_7F,
        24'h2000_00, 24'h2001_00,
        24'h3000_13, 24'h3001_05, 24'h3002_10, 24'h3003_00,
        24'h3004_93, 24'h3005_00, 24'h3006_20, 24'h3007_00
    };

    task automatic issue_load(input logic [2:0] t, input logic [31:0] a, input logic [4:0] id,
                              input int lat, input logic [31:0] v, input bit push);
        lsb2mem_ready = 1'b1; lsb2mem_load_type = t; lsb2mem_addr = a; lsb2mem_rob_id = id;
        if (push) ld_q.push_back('{cyc + 1 + lat, id, v});
        @(negedge clk_in);
        lsb2mem_ready = 1'b0;
    endtask

    task automatic issue_store(input logic [2:0] t, input logic [31:0] a, input logic [31:0] v,
                               input int nbytes, input int first_cyc);
        logic [31:0] sv;
        sv = v;
        rob2mem_ready = 1'b1; rob2mem_store_type = t; rob2mem_addr = a; rob2mem_value = v;
        for (int b = 0; b < nbytes; b++)
            wr_q.push_back('{first_cyc + b, a + 32'(b), 8'(sv >> (8 * b))});
    endtask

    task automatic wait_idle(input string name);
        int k;
        k = 0;
        while (mem_busy && k < 40) begin
            @(negedge clk_in);
            k++;
        end
        check({name, "_idle"}, 64'(mem_busy), 64'd0);
        repeat (2) @(negedge clk_in);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        int c0, a0;
        rst_in = 1'b1; rdy_in = 1'b1;
        rob2mem_ready = 1'b0; rob2mem_store_type = 3'd0; rob2mem_addr = 32'h0; rob2mem_value = 32'h0;
        lsb2mem_ready = 1'b0; lsb2mem_load_type = 3'd0; lsb2mem_addr = 32'h0; lsb2mem_rob_id = 5'd0;
        if2mem_ready = 1'b0; if2mem_addr = 32'h0; need_flush_in = 1'b0;
        repeat (2) @(negedge clk_in);

        check("rst_mem_wr",    64'(mem_wr), 64'd0);
        check("rst_mem_a",     64'(mem_a), 64'd0);
        check("rst_mem_dout",  64'(mem_dout), 64'd0);
        check("rst_mem_busy",  64'(mem_busy), 64'd0);
        check("rst_mem_valid", 64'(mem_valid), 64'd0);
        check("rst_if_valid",  64'(mem2if_valid), 64'd0);
        check("rst_value",     64'(mem_value), 64'd0);
        check("rst_instr",     64'(mem2if_instr), 64'd0);
        check("rst_dep",       64'(mem_dependency), 64'd0);

        for (int i = 0; i < 18; i++) begin
            pl_a = PRE[i][23:8]; pl_d = PRE[i][7:0]; pl_en = 1'b1;
            @(negedge clk_in);
        end
        pl_en = 1'b0;
        rst_in = 1'b0;
        @(negedge clk_in);

        // Word load: four consecutive byte reads, result four cycles after accept.
        issue_load(LOAD_LW, 32'h1000, 5'd5, 4, 32'h12345678, 1'b1);
        wait_idle("lw");

        issue_load(LOAD_LB,  32'h1100, 5'd1, 1, 32'hFFFFFF80, 1'b1); wait_idle("lb");
        issue_load(LOAD_LBU, 32'h1100, 5'd2, 1, 32'h00000080, 1'b1); wait_idle("lbu");
        issue_load(LOAD_LH,  32'h1200, 5'd3, 2, 32'h00007FFF, 1'b1); wait_idle("lh_pos");
        issue_load(LOAD_LH,  32'h1100, 5'd4, 2, 32'hFFFFFF80, 1'b1); wait_idle("lh_neg");
        issue_load(LOAD_LHU, 32'h1100, 5'd6, 2, 32'h0000FF80, 1'b1); wait_idle("lhu");

        // Half store: pulse latched, written over the next two cycles.
        c0 = cyc;
        issue_store(STORE_HALF, 32'h2002, 32'hABCD1234, 2, c0 + 2);
        @(negedge clk_in);
        rob2mem_ready = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            check("sh_busy", 64'(mem_busy), 64'(k < 4));
            @(negedge clk_in);
        end
        issue_load(LOAD_LW, 32'h2000, 5'd8, 4, 32'h12340000, 1'b1);
        wait_idle("sh_readback");

        // Store pulse during a fetch with a load waiting: fetch, then store, then load.
        c0 = cyc;
        if2mem_ready = 1'b1; if2mem_addr = 32'h3000;
        @(negedge clk_in);
        a0 = cyc;
        if2mem_ready = 1'b0;
        if_q.push_back('{a0 + 4, 32'h00100513});
        lsb2mem_ready = 1'b1; lsb2mem_load_type = LOAD_LW; lsb2mem_addr = 32'h1000; lsb2mem_rob_id = 5'd7;
        ld_q.push_back('{a0 + 14, 5'd7, 32'h12345678});
        issue_store(STORE_WORD, 32'h2100, 32'hDEADBEEF, 4, a0 + 5);
        check("mix_busy", 64'(mem_busy), 64'd1);
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk_in);
            if (k == 1)  rob2mem_ready = 1'b0;
            if (k == 10) lsb2mem_ready = 1'b0;
            if (k <= 8)  check("mix_busy", 64'(mem_busy), 64'd1);
        end
        wait_idle("mix");

        // Flush while byte 2 of a word load is on the bus: no result.
        issue_load(LOAD_LW, 32'h1000, 5'd9, 4, 32'h0, 1'b0);
        repeat (2) @(negedge clk_in);
        check("flush_addr", 64'(mem_a), 64'h1002);
        check("flush_busy_before", 64'(mem_busy), 64'd1);
        need_flush_in = 1'b1;
        @(negedge clk_in);
        need_flush_in = 1'b0;
        check("flush_idle", 64'(mem_busy), 64'd0);
        repeat (6) @(negedge clk_in);

        // Flush held across a pending and running store: all four bytes still written.
        c0 = cyc;
        issue_store(STORE_WORD, 32'h2200, 32'h0BADF00D, 4, c0 + 2);
        @(negedge clk_in);
        rob2mem_ready = 1'b0;
        need_flush_in = 1'b1;
        repeat (3) @(negedge clk_in);
        need_flush_in = 1'b0;
        wait_idle("flush_sw");

        // Three-cycle pause in the middle of a fetch.
        if2mem_ready = 1'b1; if2mem_addr = 32'h3004;
        @(negedge clk_in);
        a0 = cyc;
        if2mem_ready = 1'b0;
        if_q.push_back('{a0 + 7, 32'h00200093});
        @(negedge clk_in);
        rdy_in = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check("pause_addr_held", 64'(mem_a), 64'h3005);
            @(negedge clk_in);
        end
        rdy_in = 1'b1;
        wait_idle("pause_fetch");

        // Asynchronous reset in the middle of a word store.
        c0 = cyc;
        issue_store(STORE_WORD, 32'h2300, 32'h11223344, 2, c0 + 2);
        @(negedge clk_in);
        rob2mem_ready = 1'b0;
        @(negedge clk_in);
        check("store_busy", 64'(mem_busy), 64'd1);
        @(negedge clk_in);
        #2 rst_in = 1'b1;
        #1;
        check("arst_mem_wr",   64'(mem_wr), 64'd0);
        check("arst_mem_busy", 64'(mem_busy), 64'd0);
        check("arst_mem_a",    64'(mem_a), 64'd0);
        check("arst_mem_dout", 64'(mem_dout), 64'd0);
        check("arst_value",    64'(mem_value), 64'd0);
        check("arst_instr",    64'(mem2if_instr), 64'd0);
        check("arst_dep",      64'(mem_dependency), 64'd0);
        @(negedge clk_in);
        rst_in = 1'b0;
        repeat (4) @(negedge clk_in);

        check("ld_queue_drained", 64'(ld_q.size()), 64'd0);
        check("if_queue_drained", 64'(if_q.size()), 64'd0);
        check("wr_queue_drained", 64'(wr_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
